ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
Iterative multiply/divide unit in the execute stage, directly upstream of the MEM stage. It implements ARMv8 MUL, UDIV and SDIV, plus UMULH and SMULH when the optional feature is compiled in. It computes one bit per cycle and stalls the front of the pipeline while busy. It presents its result, together with the destination register address, to the ex/mem pipeline register feeding the MEM stage.

Parameters:
DW, 64, datapath width (matches DataBus)
AW, 5, destination register address width (matches RegAddrBus)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
start_i  in  1  request; sampled only in IDLE
op_i  in  3  000 MUL, 001 UDIV, 010 SDIV, 011 UMULH, 100 SMULH; others reserved
sf_i  in  1  1 = 64-bit X form, 0 = 32-bit W form
src_a_i  in  DW  multiplicand / dividend
src_b_i  in  DW  multiplier / divisor
waddr_i  in  AW  destination register, inst[4:0]
ack_i  in  1  pipeline advanced; consumes the result held in DONE
stall_req_o  out  1  freeze PC, IF/ID and ID/EX
valid_o  out  1  result_o and waddr_o valid
result_o  out  DW  result
waddr_o  out  AW  captured destination register

Behaviour:
- Reset (rst = 0, asynchronous): state goes to IDLE; stall_req_o = 0, valid_o = 0, result_o = 0, waddr_o = 0; all internal registers cleared. Reset mid-operation abandons the operation and produces no valid_o.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - On a start_i edge: latch op, sf, waddr and operands.
  - W form: use operands[31:0] only, zero-extended for unsigned ops, sign-extended for SDIV.
  - Signed ops: take absolute values and record the result sign (dividend sign XOR divisor sign).
  - Set iteration count N = 64 (X form) or 32 (W form). Go to BUSY.
  - Zero-fast path: if a divide has divisor 0, or op is reserved, go directly to FIX with result 0.
- BUSY:
  - One iteration per clock: shift-add multiply (128-bit accumulator) or restoring division (quotient only).
  - After the N-th iteration go to FIX.
- FIX:
  - Apply sign negation: SDIV quotient, or the SMULH 128-bit product.
  - Select output: MUL low half; UMULH/SMULH high half; divide quotient.
  - W form: zero result[63:32].
  - Register result_o and waddr_o, go to DONE.
- DONE: valid_o = 1, holding result_o and waddr_o stable. When ack_i = 1, go to IDLE and clear valid_o on the same edge. start_i in DONE is ignored.
- stall_req_o = (IDLE & start_i) | BUSY | FIX. This is combinational so the requesting instruction is held on its first cycle.
- Latency, counted in rising edges from the start edge to valid_o high: N+2. That is 66 for X form, 34 for W form, and 2 for the zero-fast path.
- Arithmetic rules:
  - Division truncates toward zero.
  - SDIV INT_MIN / -1 = INT_MIN (no trap).
  - Division by zero returns 0.
  - MUL low half is sign-agnostic.
- UMULH/SMULH are always X form; sf_i is ignored for them.
- ack_i outside DONE has no effect.

Optional Feature:
MDU_MULH_EN
- Defined: UMULH (011) and SMULH (100) are supported as described above.
- Not defined: 011 and 100 are reserved. They take the zero-fast path, result 0, latency 2. The 128-bit accumulator shrinks to 64 bits.

Test Plan:
1. X-form MUL: sf = 1, a = 0x0000_0001_0000_0003, b = 5, waddr = 7 -> valid_o on edge 66, result 0x0000_0005_0000_000F, waddr_o 7; stall_req_o high from the start cycle until DONE.
2. W-form SDIV: sf = 0, a = 0xFFFF_FFFF_FFFF_FFF9 (-7), b = 2 -> valid_o on edge 34, result 0x0000_0000_FFFF_FFFD (-3 zero-extended).
3. Division by zero: UDIV, a = 123, b = 0 -> valid_o on edge 2, result 0; then X-form SDIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000.
4. SMULH (MDU_MULH_EN defined): a = -1, b = -1 -> result 0. UMULH a = b = 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. Without the macro, the same ops return 0 at edge 2.
5. Handshake: hold ack_i = 0 for 10 cycles in DONE -> valid_o and result_o stable, stall_req_o = 0, start_i ignored. Pulse ack_i -> IDLE next edge; a new start is accepted on the following edge.
6. Reset mid-operation: assert rst = 0 at BUSY iteration 20 -> outputs immediately 0, no valid_o after release; a subsequent MUL 3 × 4 returns 12.

Source files
------------

// File: rtl/ex_mdu.sv
// Iterative one-bit-per-cycle multiply/divide unit for the execute stage.
// Optional UMULH/SMULH support is compiled in with `define MDU_MULH_EN.
module ex_mdu #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [2:0]    op_i,
  input  logic          sf_i,
  input  logic [DW-1:0] src_a_i,
  input  logic [DW-1:0] src_b_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          ack_i,
  output logic          stall_req_o,
  output logic          valid_o,
  output logic [DW-1:0] result_o,
  output logic [AW-1:0] waddr_o
);

  localparam int HW = DW / 2;
  localparam int CW = $clog2(DW) + 1;
`ifdef MDU_MULH_EN
  localparam int PW = 2 * DW;
  localparam bit HAS_MULH = 1'b1;
`else
  localparam int PW = DW;
  localparam bit HAS_MULH = 1'b0;
`endif

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UDIV  = 3'b001;
  localparam logic [2:0] OP_SDIV  = 3'b010;
  localparam logic [2:0] OP_UMULH = 3'b011;
  localparam logic [2:0] OP_SMULH = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic          d_mul, d_mulh, d_div, d_sgn;
  logic          d_x, d_zero;
  logic          a_neg, b_neg;
  logic [DW-1:0] a_ext, b_ext;
  logic [DW-1:0] a_abs, b_abs;

  logic          div_q, mulh_q, x_q;
  logic          neg_q, zero_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] waddr_q;
  logic [PW-1:0] opa_q;
  logic [DW-1:0] opb_q;
  logic [PW-1:0] acc_q;

  logic [DW:0]   trial, diff;
  logic          take;
  logic [PW-1:0] mag, sgn_v;
  logic [DW-1:0] res_v;

  always_comb begin
    d_mul  = 1'b0;
    d_mulh = 1'b0;
    d_div  = 1'b0;
    d_sgn  = 1'b0;
    unique case (1'b1)
      op_i == OP_MUL:  d_mul = 1'b1;
      op_i == OP_UDIV: d_div = 1'b1;
      op_i == OP_SDIV: begin
        d_div = 1'b1;
        d_sgn = 1'b1;
      end
      op_i == OP_UMULH: d_mulh = HAS_MULH;
      op_i == OP_SMULH: begin
        d_mulh = HAS_MULH;
        d_sgn  = HAS_MULH;
      end
      default: ;
    endcase
  end

  // High-half multiplies are always full width regardless of sf_i.
  always_comb begin
    d_x = sf_i | d_mulh;
    if (d_x) begin
      a_ext = src_a_i;
      b_ext = src_b_i;
    end else begin
      a_ext = {{HW{d_sgn & src_a_i[HW-1]}}, src_a_i[HW-1:0]};
      b_ext = {{HW{d_sgn & src_b_i[HW-1]}}, src_b_i[HW-1:0]};
    end
    a_neg  = d_sgn & a_ext[DW-1];
    b_neg  = d_sgn & b_ext[DW-1];
    a_abs  = a_neg ? -a_ext : a_ext;
    b_abs  = b_neg ? -b_ext : b_ext;
    d_zero = ~(d_mul | d_mulh | d_div)
           | (d_div & (b_ext == '0));
  end

  // Restoring step: remainder stays below divisor, so diff's MSB is the borrow.
  always_comb begin
    trial = {acc_q[DW-1:0], opa_q[DW-1]};
    diff  = trial - {1'b0, opb_q};
    take  = ~diff[DW];
  end

  always_comb begin
    mag   = div_q ? PW'(opa_q[DW-1:0]) : acc_q;
    sgn_v = neg_q ? -mag : mag;
    if (zero_q) begin
      res_v = '0;
    end else if (mulh_q) begin
      res_v = sgn_v[PW-1 -: DW];
    end else begin
      res_v = sgn_v[DW-1:0];
    end
    if (!x_q) begin
      res_v[DW-1:HW] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nx = d_zero ? S_FIX : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_nx = S_FIX;
        end
      end
      S_FIX: state_nx = S_DONE;
      S_DONE: begin
        if (ack_i) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stall_req_o = (state == S_IDLE && start_i)
                | (state == S_BUSY)
                | (state == S_FIX);
    valid_o     = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= 1'b0;
      mulh_q   <= 1'b0;
      x_q      <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      waddr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_o <= '0;
      waddr_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            div_q   <= d_div;
            mulh_q  <= d_mulh;
            x_q     <= d_x;
            neg_q   <= a_neg ^ b_neg;
            zero_q  <= d_zero;
            cnt_q   <= d_x ? CW'(DW) : CW'(HW);
            waddr_q <= waddr_i;
            opb_q   <= b_abs;
            acc_q   <= '0;
            // W-form dividends are pre-aligned to the top half.
            if (d_div) begin
              opa_q <= d_x ? PW'(a_abs) : PW'(a_abs << HW);
            end else begin
              opa_q <= PW'(a_abs);
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (div_q) begin
            acc_q <= take ? PW'(diff[DW-1:0]) : PW'(trial[DW-1:0]);
            opa_q <= PW'({opa_q[DW-2:0], take});
          end else begin
            if (opb_q[0]) begin
              acc_q <= acc_q + opa_q;
            end
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
          end
        end
        S_FIX: begin
          result_o <= res_v;
          waddr_o  <= waddr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu with a cycle-level behavioural reference.
// Build with +define+MDU_MULH_EN to exercise the high-half multiplies.
module tb_ex_mdu;

`ifdef MDU_MULH_EN
  localparam bit MULH = 1'b1;
`else
  localparam bit MULH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic        sf_i = 1'b0;
  logic [63:0] src_a_i = '0;
  logic [63:0] src_b_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        ack_i = 1'b0;
  logic        stall_req_o;
  logic        valid_o;
  logic [63:0] result_o;
  logic [4:0]  waddr_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mdu #(.DW(64), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .sf_i        (sf_i),
    .src_a_i     (src_a_i),
    .src_b_i     (src_b_i),
    .waddr_i     (waddr_i),
    .ack_i       (ack_i),
    .stall_req_o (stall_req_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .waddr_o     (waddr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic is_x(input logic [2:0] op, input logic sf);
    return sf || (MULH && (op == 3'd3 || op == 3'd4));
  endfunction

  function automatic logic [63:0] model_res(input logic [2:0] op,
    input logic sf, input logic [63:0] a, input logic [63:0] b);
    logic               x;
    logic [63:0]        r;
    logic [127:0]       up;
    logic signed [127:0] sa, sb, sp;
    x = is_x(op, sf);
    if (!x) begin
      if (op == 3'd2) begin
        a = {{32{a[31]}}, a[31:0]};
        b = {{32{b[31]}}, b[31:0]};
      end else begin
        a = {32'b0, a[31:0]};
        b = {32'b0, b[31:0]};
      end
    end
    r = '0;
    case (op)
      3'd0: r = a * b;
      3'd1: r = (b == 0) ? 64'd0 : a / b;
      3'd2: begin
        if (b == 0) r = '0;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd3: if (MULH) begin
        up = {64'b0, a} * {64'b0, b};
        r = up[127:64];
      end
      3'd4: if (MULH) begin
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        sp = sa * sb;
        r = sp[127:64];
      end
      default: r = '0;
    endcase
    if (!x) r[63:32] = '0;
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic sf,
                                   input logic [63:0] b);
    logic        x;
    logic        known;
    logic [63:0] be;
    x     = is_x(op, sf);
    be    = x ? b : {32'b0, b[31:0]};
    known = (op <= 3'd2) || (MULH && op <= 3'd4);
    if (!known || ((op == 3'd1 || op == 3'd2) && be == 0)) return 2;
    return x ? 66 : 34;
  endfunction

  // Reference: 0 idle, 1 working (edges left in m_rem), 2 result held
  int          m_phase = 0;
  int          m_rem = 0;
  logic [63:0] m_res = '0;
  logic [4:0]  m_waddr = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start_i) begin
          m_res   = model_res(op_i, sf_i, src_a_i, src_b_i);
          m_waddr = waddr_i;
          m_rem   = model_lat(op_i, sf_i, src_b_i) - 1;
          m_phase = 1;
        end
        1: begin
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
        default: if (ack_i) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("stall", 64'(stall_req_o),
            64'((m_phase == 0 && start_i) || m_phase == 1));
      check("valid", 64'(valid_o), 64'(m_phase == 2));
      if (m_phase == 2) begin
        check("result", result_o, m_res);
        check("waddr", 64'(waddr_o), 64'(m_waddr));
      end
    end
  end

  // Called #1 after a rising edge; starts on the next edge.
  task automatic run_op(input logic [2:0] op, input logic sf,
    input logic [63:0] a, input logic [63:0] b, input logic [4:0] wa,
    input logic [63:0] exp_res, input int exp_lat, input bit do_ack);
    int n;
    op_i = op;
    sf_i = sf;
    src_a_i = a;
    src_b_i = b;
    waddr_i = wa;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 1;
    while (!valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("op_result", result_o, exp_res);
    check("op_waddr", 64'(waddr_o), 64'(wa));
    if (do_ack) begin
      ack_i = 1'b1;
      @(posedge clk);
      #1;
      ack_i = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_stall", 64'(stall_req_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_waddr", 64'(waddr_o), 64'd0);
    @(posedge clk);
    #1;

    run_op(3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'd5, 5'd7,
           64'h0000_0005_0000_000F, 66, 1);
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3,
           64'h0000_0000_FFFF_FFFD, 34, 1);
    run_op(3'd1, 1'b1, 64'd123, 64'd0, 5'd4, 64'd0, 2, 1);
    run_op(3'd2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           5'd5, 64'h8000_0000_0000_0000, 66, 1);
    run_op(3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd6,
           64'hFFFF_FFFF_FFFF_FFF2, 66, 1);
    run_op(3'd1, 1'b0, 64'hDEAD_0000_0000_0064, 64'h1234_0000_0000_0007,
           5'd8, 64'd14, 34, 1);
    run_op(3'd0, 1'b0, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
           5'd10, 64'd1, 34, 1);
    run_op(3'd2, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           5'd11, 64'h0000_0000_8000_0000, 34, 1);
    run_op(3'd1, 1'b0, 64'd55, 64'h0000_0001_0000_0000, 5'd12, 64'd0, 2, 1);
    run_op(3'd7, 1'b1, 64'd9, 64'd9, 5'd13, 64'd0, 2, 1);
`ifdef MDU_MULH_EN
    run_op(3'd4, 1'b1, '1, '1, 5'd14, 64'd0, 66, 1);
    run_op(3'd3, 1'b0, '1, '1, 5'd15, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1);
    run_op(3'd4, 1'b1, '1, 64'd1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1);
`else
    run_op(3'd4, 1'b1, '1, '1, 5'd14, 64'd0, 2, 1);
    run_op(3'd3, 1'b1, '1, '1, 5'd15, 64'd0, 2, 1);
`endif

    // Result held while the pipeline does not advance
    run_op(3'd1, 1'b1, 64'd1000, 64'd10, 5'd9, 64'd100, 66, 0);
    for (int i = 0; i < 10; i++) begin
      start_i = i[0];
      op_i = 3'd0;
      src_a_i = 64'(i + 1);
      @(posedge clk);
      #1;
      check("hold_valid", 64'(valid_o), 64'd1);
      check("hold_result", result_o, 64'd100);
      check("hold_waddr", 64'(waddr_o), 64'd9);
      check("hold_stall", 64'(stall_req_o), 64'd0);
    end
    start_i = 1'b0;
    ack_i = 1'b1;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
    check("ack_valid", 64'(valid_o), 64'd0);
    run_op(3'd1, 1'b1, 64'd100, 64'd7, 5'd17, 64'd14, 66, 1);

    // Abandon an operation mid-flight
    op_i = 3'd0;
    sf_i = 1'b1;
    src_a_i = 64'd1234;
    src_b_i = 64'd5678;
    waddr_i = 5'd18;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_stall", 64'(stall_req_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_waddr", 64'(waddr_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("midrst_novalid", 64'(valid_o), 64'd0);
    run_op(3'd0, 1'b1, 64'd3, 64'd4, 5'd19, 64'd12, 66, 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
